// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, optional skid entry and flush.
// Latency: 1 cycle from in_fire to out_valid when empty; sustains 1 transfer/cycle.
// Backpressure: SKID=1 absorbs one beat behind a registered in_ready; SKID=0 has a combinational in_ready.
module pipe_stage_reg #(
  parameter int                DATA_W     = 64,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = DATA_W'(64'h0000_0000_0000_0013),
  parameter bit                SKID       = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  // State is the number of occupied entries; TWO is only reachable with a skid entry.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_nxt_state;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] w_nxt_main;
  logic [DATA_W-1:0] r_skid;
  logic [DATA_W-1:0] w_nxt_skid;
  logic              r_out_valid;
  logic              w_in_fire;
  logic              w_out_fire;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  // Next-state and next-payload selection; flush overrides every transition.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_main  = r_main;
    w_nxt_skid  = r_skid;
    if (flush) begin
      w_nxt_state = ST_EMPTY;
      w_nxt_main  = BUBBLE_VAL;
      w_nxt_skid  = BUBBLE_VAL;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_nxt_state = ST_ONE;
            w_nxt_main  = in_data;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_nxt_main = in_data;
          end else if (w_in_fire && SKID) begin
            // Downstream stalled: park the new beat behind the main entry.
            w_nxt_state = ST_TWO;
            w_nxt_skid  = in_data;
          end else if (w_out_fire) begin
            w_nxt_state = ST_EMPTY;
            w_nxt_main  = BUBBLE_VAL;
          end
        end
        ST_TWO: begin
          if (w_out_fire) begin
            w_nxt_state = ST_ONE;
            w_nxt_main  = r_skid;
            w_nxt_skid  = BUBBLE_VAL;
          end
        end
        default: begin
          w_nxt_state = ST_EMPTY;
          w_nxt_main  = BUBBLE_VAL;
          w_nxt_skid  = BUBBLE_VAL;
        end
      endcase
    end
  end

  // State and payload registers; reset drops every held entry and restores the bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_main      <= BUBBLE_VAL;
      r_skid      <= BUBBLE_VAL;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_main      <= w_nxt_main;
      r_skid      <= w_nxt_skid;
      r_out_valid <= (w_nxt_state != ST_EMPTY);
    end
  end

  generate
    if (SKID) begin : g_skid
      logic r_in_ready;
      // Registered ready: low exactly while both entries are occupied.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_in_ready <= 1'b1;
        end else begin
          r_in_ready <= (w_nxt_state != ST_TWO);
        end
      end
      assign in_ready = r_in_ready;
    end else begin : g_noskid
      // Single entry: accept when empty or when the held beat leaves this cycle.
      assign in_ready = ~r_out_valid | out_ready;
    end
  endgenerate

  assign out_valid = r_out_valid;
  assign out_data  = r_main;
  assign count     = r_state;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vectors on SKID=1 and SKID=0 instances, then random handshake.
// Latency: expectations are checked #1 after the clock edge or on the falling edge.
// Backpressure: out_ready is driven directly and randomly toggled in the soak phase.
module tb_pipe_stage_reg;

  localparam logic [63:0] BUB = 64'h0000_0000_0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [63:0] a_in_data, a_out_data;
  logic [1:0]  a_count;
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [63:0] b_in_data, b_out_data;
  logic [1:0]  b_count;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(64), .BUBBLE_VAL(BUB), .SKID(1'b1)) u_dut_skid (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .count(a_count)
  );

  pipe_stage_reg #(.DATA_W(64), .BUBBLE_VAL(BUB), .SKID(1'b0)) u_dut_noskid (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .count(b_count)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] qa[$];
  logic [63:0] qb[$];
  logic [63:0] a_next, b_next;
  int          a_pop, b_pop;

  initial begin
    rst = 1'b1;
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = '0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0;
    #1;
    // Reset state
    chk("rst_vld",   64'(a_out_valid), 64'd0);
    chk("rst_data",  a_out_data, BUB);
    chk("rst_cnt",   64'(a_count), 64'd0);
    chk("rst_rdy",   64'(a_in_ready), 64'd1);
    step();
    step();
    rst = 1'b0;
    step();
    chk("post_rst_rdy", 64'(a_in_ready), 64'd1);

    // Streaming with out_ready held high
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_data   = 64'h0000_0004_0000_0093;
    step();
    chk("str1_vld",  64'(a_out_valid), 64'd1);
    chk("str1_data", a_out_data, 64'h0000_0004_0000_0093);
    chk("str1_cnt",  64'(a_count), 64'd1);
    a_in_data = 64'h0000_0008_0000_0113;
    step();
    chk("str2_vld",  64'(a_out_valid), 64'd1);
    chk("str2_data", a_out_data, 64'h0000_0008_0000_0113);
    chk("str2_cnt",  64'(a_count), 64'd1);
    a_in_valid = 1'b0;
    step();
    chk("str_end_vld",  64'(a_out_valid), 64'd0);
    chk("str_end_data", a_out_data, BUB);

    // Back-pressure fills the skid entry
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 64'h0000_0000_0000_00A1;
    step();
    chk("bp_a_cnt", 64'(a_count), 64'd1);
    a_in_data = 64'h0000_0000_0000_00B2;
    step();
    chk("bp_b_cnt",  64'(a_count), 64'd2);
    chk("bp_b_rdy",  64'(a_in_ready), 64'd0);
    chk("bp_b_data", a_out_data, 64'h0000_0000_0000_00A1);
    a_in_data = 64'h0000_0000_0000_00C3;
    step();
    chk("bp_hold_cnt",  64'(a_count), 64'd2);
    chk("bp_hold_data", a_out_data, 64'h0000_0000_0000_00A1);
    a_out_ready = 1'b1;
    step();
    chk("bp_rel1_data", a_out_data, 64'h0000_0000_0000_00B2);
    chk("bp_rel1_cnt",  64'(a_count), 64'd1);
    chk("bp_rel1_rdy",  64'(a_in_ready), 64'd1);
    step();
    chk("bp_rel2_data", a_out_data, 64'h0000_0000_0000_00C3);
    chk("bp_rel2_cnt",  64'(a_count), 64'd1);
    a_in_valid = 1'b0;
    step();
    chk("bp_drain_vld", 64'(a_out_valid), 64'd0);

    // Flush with a same-cycle input beat
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 64'h0000_0000_0000_00A1;
    step();
    a_in_data = 64'h0000_0000_0000_00B2;
    step();
    chk("fl_pre_cnt", 64'(a_count), 64'd2);
    a_flush   = 1'b1;
    a_in_data = 64'h0000_0000_0000_00D4;
    step();
    chk("fl_vld",  64'(a_out_valid), 64'd0);
    chk("fl_data", a_out_data, BUB);
    chk("fl_cnt",  64'(a_count), 64'd0);
    chk("fl_rdy",  64'(a_in_ready), 64'd1);
    a_flush     = 1'b0;
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    step();
    chk("fl_no_d_vld", 64'(a_out_valid), 64'd0);

    // Asynchronous reset while full
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 64'h0000_0000_0000_00A1;
    step();
    a_in_data = 64'h0000_0000_0000_00B2;
    step();
    chk("ar_pre_cnt", 64'(a_count), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_vld",  64'(a_out_valid), 64'd0);
    chk("ar_data", a_out_data, BUB);
    chk("ar_cnt",  64'(a_count), 64'd0);
    chk("ar_rdy",  64'(a_in_ready), 64'd1);
    a_in_valid = 1'b0;
    #2;
    rst = 1'b0;
    step();
    chk("ar_rel_cnt", 64'(a_count), 64'd0);
    chk("ar_rel_rdy", 64'(a_in_ready), 64'd1);
    chk("ar_rel_vld", 64'(a_out_valid), 64'd0);

    // Single-entry variant: combinational ready and in-place replacement
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1;
    b_in_data   = 64'h0000_0000_0000_00E5;
    step();
    chk("ns_cnt1",  64'(b_count), 64'd1);
    chk("ns_data1", b_out_data, 64'h0000_0000_0000_00E5);
    chk("ns_rdy0",  64'(b_in_ready), 64'd0);
    b_out_ready = 1'b1;
    #1;
    chk("ns_rdy1",  64'(b_in_ready), 64'd1);
    b_in_data = 64'h0000_0000_0000_00F6;
    step();
    chk("ns_data2", b_out_data, 64'h0000_0000_0000_00F6);
    chk("ns_cnt2",  64'(b_count), 64'd1);
    b_in_valid = 1'b0;
    step();
    chk("ns_cnt0",  64'(b_count), 64'd0);
    chk("ns_bub",   b_out_data, BUB);

    // Random handshake soak on both instances against queue scoreboards
    a_next = 64'hA000_0000_0000_0000;
    b_next = 64'hB000_0000_0000_0000;
    a_pop  = 0;
    b_pop  = 0;
    for (int i = 0; i < 10008; i++) begin
      if (i < 10000) begin
        a_in_valid  = 1'($urandom_range(0, 1));
        a_out_ready = ($urandom_range(0, 9) < 6);
        b_in_valid  = 1'($urandom_range(0, 1));
        b_out_ready = ($urandom_range(0, 9) < 6);
      end else begin
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
      end
      a_in_data = a_next;
      b_in_data = b_next;
      @(negedge clk);
      chk("rnd_a_cnt", 64'(a_count), 64'(qa.size()));
      chk("rnd_b_cnt", 64'(b_count), 64'(qb.size()));
      if (!a_out_valid) chk("rnd_a_bub", a_out_data, BUB);
      if (!b_out_valid) chk("rnd_b_bub", b_out_data, BUB);
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) chk("rnd_a_spur", 64'(qa.size()), 64'd1);
        else begin
          chk("rnd_a_ord", a_out_data, qa.pop_front());
          a_pop++;
        end
      end
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) chk("rnd_b_spur", 64'(qb.size()), 64'd1);
        else begin
          chk("rnd_b_ord", b_out_data, qb.pop_front());
          b_pop++;
        end
      end
      if (a_in_valid && a_in_ready) begin
        qa.push_back(a_in_data);
        a_next++;
      end
      if (b_in_valid && b_in_ready) begin
        qb.push_back(b_in_data);
        b_next++;
      end
      @(posedge clk);
      #1;
    end
    chk("rnd_a_left", 64'(qa.size()), 64'd0);
    chk("rnd_b_left", 64'(qb.size()), 64'd0);
    chk("rnd_a_xfer", 64'(a_pop), a_next - 64'hA000_0000_0000_0000);
    chk("rnd_b_xfer", 64'(b_pop), b_next - 64'hB000_0000_0000_0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
